// File: rtl/game_pkg.sv
// Shared constants for the screen painters: draw modes, default screen size,
// colour width and the painter state encoding.
package game_pkg;

    localparam int COLOR_W   = 12;
    localparam int SCR_W_DEF = 160;
    localparam int SCR_H_DEF = 120;

    localparam logic [1:0] MODE_FILL  = 2'd0;
    localparam logic [1:0] MODE_IMAGE = 2'd1;
    localparam logic [1:0] MODE_KEYED = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Mode 3 is reserved and paints like FILL, so only IMAGE/KEYED read the ROM.
    function automatic logic uses_rom(input logic [1:0] m);
        return (m == MODE_IMAGE) || (m == MODE_KEYED);
    endfunction

endpackage

// File: rtl/m_raster_counter.sv
// Row-major column/row walker with a linear address that simply counts up,
// so the image address row*width+col never needs a multiplier.
module m_raster_counter #(
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int ADDR_W = 15
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              clear,
    input  logic              advance,
    input  logic [X_W-1:0]    width,
    input  logic [Y_W-1:0]    height,
    output logic [X_W-1:0]    col,
    output logic [Y_W-1:0]    row,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic col_end;

    assign col_end = (col == width - X_W'(1));
    assign last    = col_end && (row == height - Y_W'(1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (clear) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (advance) begin
            addr <= addr + ADDR_W'(1);
            if (col_end) begin
                col <= '0;
                row <= last ? '0 : row + Y_W'(1);
            end else begin
                col <= col + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/m_screen_painter.sv
// Rectangle renderer: walks a rectangle row-major and drives the VGA pixel
// write port through a two-stage pipeline (issue, then clip/key/colour).
module m_screen_painter #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = game_pkg::COLOR_W,
    parameter int ADDR_W  = 15,
    parameter int SCR_W   = game_pkg::SCR_W_DEF,
    parameter int SCR_H   = game_pkg::SCR_H_DEF,
    parameter logic [COLOR_W-1:0] KEY_COLOR = COLOR_W'(12'h0F0)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               enable,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [X_W-1:0]     rect_x,
    input  logic [Y_W-1:0]     rect_y,
    input  logic [X_W-1:0]     rect_w,
    input  logic [Y_W-1:0]     rect_h,
    input  logic [COLOR_W-1:0] fill_color,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [X_W-1:0]     VGA_X,
    output logic [Y_W-1:0]     VGA_Y,
    output logic [COLOR_W-1:0] VGA_COLOR,
    output logic               plot,
    output logic               busy,
    output logic               finished
);

    import game_pkg::*;

    state_t             state_reg;
    logic [1:0]         mode_reg;
    logic [X_W-1:0]     rx_reg, rw_reg;
    logic [Y_W-1:0]     ry_reg, rh_reg;
    logic [COLOR_W-1:0] fill_reg;
    logic               busy_reg, finished_reg;

    logic               s1_valid_reg, s1_last_reg;
    logic [X_W-1:0]     s1_col_reg;
    logic [Y_W-1:0]     s1_row_reg;

    logic [X_W-1:0]     vga_x_reg;
    logic [Y_W-1:0]     vga_y_reg;
    logic [COLOR_W-1:0] vga_color_reg;
    logic               plot_reg;

    logic [X_W-1:0]     cnt_col;
    logic [Y_W-1:0]     cnt_row;
    logic [ADDR_W-1:0]  cnt_addr;
    logic               cnt_last;
    logic               run_issue, issue, cnt_clear;

    logic [X_W:0]       sum_x;
    logic [Y_W:0]       sum_y;
    logic               keyed_out, visible;

    // Once the last pixel sits in stage 1, RUN spends one more cycle draining it.
    assign run_issue = (state_reg == ST_RUN) && !(s1_valid_reg && s1_last_reg);
    assign issue     = enable && run_issue;
    assign cnt_clear = enable && (state_reg == ST_LOAD);

    m_raster_counter #(
        .X_W    (X_W),
        .Y_W    (Y_W),
        .ADDR_W (ADDR_W)
    ) u_raster (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (cnt_clear),
        .advance (issue),
        .width   (rw_reg),
        .height  (rh_reg),
        .col     (cnt_col),
        .row     (cnt_row),
        .addr    (cnt_addr),
        .last    (cnt_last)
    );

    // Extra carry bit: a sum that wraps the coordinate width counts as off-screen.
    assign sum_x     = {1'b0, rx_reg} + {1'b0, s1_col_reg};
    assign sum_y     = {1'b0, ry_reg} + {1'b0, s1_row_reg};
    assign keyed_out = (mode_reg == MODE_KEYED) && (rom_data == KEY_COLOR);
    assign visible   = s1_valid_reg && (sum_x < (X_W+1)'(SCR_W))
                       && (sum_y < (Y_W+1)'(SCR_H)) && !keyed_out;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            mode_reg     <= MODE_FILL;
            rx_reg       <= '0;
            ry_reg       <= '0;
            rw_reg       <= '0;
            rh_reg       <= '0;
            fill_reg     <= '0;
            busy_reg     <= 1'b0;
            finished_reg <= 1'b0;
        end else if (enable) begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_reg     <= mode;
                        rx_reg       <= rect_x;
                        ry_reg       <= rect_y;
                        rw_reg       <= rect_w;
                        rh_reg       <= rect_h;
                        fill_reg     <= fill_color;
                        state_reg    <= ST_LOAD;
                        busy_reg     <= 1'b1;
                        finished_reg <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (rw_reg == '0 || rh_reg == '0) begin
                        state_reg    <= ST_DONE;
                        busy_reg     <= 1'b0;
                        finished_reg <= 1'b1;
                    end else begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (s1_valid_reg && s1_last_reg) begin
                        state_reg <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    state_reg    <= ST_DONE;
                    busy_reg     <= 1'b0;
                    finished_reg <= 1'b1;
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    busy_reg     <= 1'b0;
                    finished_reg <= 1'b0;
                end
            endcase
        end
    end

    // ROM data arrives alongside stage 1, so colour and keying resolve into stage 2.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid_reg  <= 1'b0;
            s1_last_reg   <= 1'b0;
            s1_col_reg    <= '0;
            s1_row_reg    <= '0;
            vga_x_reg     <= '0;
            vga_y_reg     <= '0;
            vga_color_reg <= '0;
            plot_reg      <= 1'b0;
        end else if (enable) begin
            s1_valid_reg  <= run_issue;
            s1_last_reg   <= cnt_last;
            s1_col_reg    <= cnt_col;
            s1_row_reg    <= cnt_row;
            vga_x_reg     <= sum_x[X_W-1:0];
            vga_y_reg     <= sum_y[Y_W-1:0];
            vga_color_reg <= uses_rom(mode_reg) ? rom_data : fill_reg;
            plot_reg      <= visible;
        end
    end

    assign rom_addr  = cnt_addr;
    assign VGA_X     = vga_x_reg;
    assign VGA_Y     = vga_y_reg;
    assign VGA_COLOR = vga_color_reg;
    assign plot      = plot_reg && enable;
    assign busy      = busy_reg;
    assign finished  = finished_reg;

endmodule

// File: tb/tb_m_screen_painter.sv
// Scoreboard bench for m_screen_painter: expected pixels are queued when a
// draw is launched and popped as the painter plots them.
module tb_m_screen_painter;

    logic        clock;
    logic        resetn;
    logic        enable;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  rect_x, rect_w;
    logic [6:0]  rect_y, rect_h;
    logic [11:0] fill_color;
    logic [14:0] rom_addr;
    logic [11:0] rom_data;
    logic [7:0]  VGA_X;
    logic [6:0]  VGA_Y;
    logic [11:0] VGA_COLOR;
    logic        plot, busy, finished;

    typedef struct packed {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [11:0] c;
    } pix_t;

    pix_t        sb[$];
    pix_t        got_pix;
    logic [11:0] rom_mem [0:1023];
    int          total = 0;
    int          bad   = 0;
    int          plot_cnt = 0;

    m_screen_painter dut (
        .clock      (clock),
        .resetn     (resetn),
        .enable     (enable),
        .start      (start),
        .mode       (mode),
        .rect_x     (rect_x),
        .rect_y     (rect_y),
        .rect_w     (rect_w),
        .rect_h     (rect_h),
        .fill_color (fill_color),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .VGA_X      (VGA_X),
        .VGA_Y      (VGA_Y),
        .VGA_COLOR  (VGA_COLOR),
        .plot       (plot),
        .busy       (busy),
        .finished   (finished)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous image ROM: data follows the address by one clock.
    always @(posedge clock) rom_data <= rom_mem[rom_addr[9:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (plot) begin
            plot_cnt++;
            if (sb.size() == 0) begin
                chk("extra_plot", 32'd1, 32'd0);
            end else begin
                got_pix = sb.pop_front();
                chk("px_x", {24'd0, VGA_X}, {24'd0, got_pix.x});
                chk("px_y", {25'd0, VGA_Y}, {25'd0, got_pix.y});
                chk("px_color", {20'd0, VGA_COLOR}, {20'd0, got_pix.c});
            end
        end
    end

    task automatic draw(input logic [1:0] m, input logic [7:0] x, input logic [6:0] y,
                        input logic [7:0] w, input logic [6:0] h, input logic [11:0] c,
                        input int stall_at, input int busy_start, input int exp_lat,
                        input string name);
        int   n;
        int   exp_cnt;
        bit   done;
        pix_t p;
        exp_cnt = 0;
        for (int r = 0; r < int'(h); r++) begin
            for (int k = 0; k < int'(w); k++) begin
                int          sx, sy, a;
                logic [11:0] col;
                sx  = int'(x) + k;
                sy  = int'(y) + r;
                a   = r * int'(w) + k;
                col = (m == 2'd1 || m == 2'd2) ? rom_mem[a] : c;
                if (sx < 160 && sy < 120 && !(m == 2'd2 && col == 12'h0F0)) begin
                    p.x = sx[7:0];
                    p.y = sy[6:0];
                    p.c = col;
                    sb.push_back(p);
                    exp_cnt++;
                end
            end
        end
        plot_cnt = 0;
        @(negedge clock);
        mode = m; rect_x = x; rect_y = y; rect_w = w; rect_h = h; fill_color = c;
        enable = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(posedge clock);
            n++;
            #1;
            if (busy_start != 0 && n == 1) begin
                chk({name, "_busy"}, {31'd0, busy}, 32'd1);
                start = 1'b1;
                rect_x = x + 8'd3;
                fill_color = ~c;
                mode = 2'd1;
            end
            if (busy_start != 0 && n == 2) start = 1'b0;
            if (stall_at > 0 && n == stall_at) enable = 1'b0;
            if (stall_at > 0 && n == stall_at + 5) enable = 1'b1;
            if (finished) done = 1'b1;
        end
        chk({name, "_lat"}, n, exp_lat);
        @(negedge clock);
        chk({name, "_pending"}, sb.size(), 32'd0);
        chk({name, "_plots"}, plot_cnt, exp_cnt);
        $display("draw %s mode=%0d at (%0d,%0d) %0dx%0d latency=%0d plots=%0d", name, m, x, y,
                 w, h, n, plot_cnt);
        sb.delete();
    endtask

    initial begin
        int n;
        int plots_at_reset;
        resetn = 1'b0; enable = 1'b1; start = 1'b0; mode = 2'd0;
        rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; fill_color = '0;
        for (int i = 0; i < 1024; i++) rom_mem[i] = 12'h000;
        repeat (3) @(negedge clock);
        chk("rst_plot", {31'd0, plot}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_finished", {31'd0, finished}, 32'd0);
        chk("rst_vga", {VGA_X, 1'b0, VGA_Y, VGA_COLOR}, 32'd0);
        chk("rst_rom_addr", {17'd0, rom_addr}, 32'd0);
        resetn = 1'b1;

        draw(2'd0, 8'd10, 7'd20, 8'd4, 7'd2, 12'hF00, 0, 0, 11, "fill");
        for (int i = 0; i < 16; i++) rom_mem[i] = 12'(i);
        draw(2'd1, 8'd0, 7'd0, 8'd3, 7'd2, 12'hABC, 0, 0, 9, "image");
        draw(2'd0, 8'd158, 7'd119, 8'd4, 7'd2, 12'h00F, 0, 0, 11, "clip");
        rom_mem[0] = 12'h0F0; rom_mem[1] = 12'h123; rom_mem[2] = 12'h0F0; rom_mem[3] = 12'h456;
        draw(2'd2, 8'd30, 7'd40, 8'd2, 7'd2, 12'h777, 0, 0, 7, "keyed");
        draw(2'd3, 8'd5, 7'd6, 8'd4, 7'd1, 12'h0AA, 4, 1, 12, "stall");
        draw(2'd0, 8'd1, 7'd1, 8'd0, 7'd3, 12'hFFF, 0, 0, 1, "zero");

        // Abort a FILL mid-draw with reset; nothing may plot afterwards.
        @(negedge clock);
        mode = 2'd0; rect_x = 8'd50; rect_y = 7'd50; rect_w = 8'd4; rect_h = 7'd2;
        fill_color = 12'h0C0;
        for (int k = 0; k < 8; k++) begin
            got_pix.x = 8'(50 + (k % 4));
            got_pix.y = 7'(50 + (k / 4));
            got_pix.c = 12'h0C0;
            sb.push_back(got_pix);
        end
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        n = 0;
        while (n < 5) begin
            @(posedge clock);
            n++;
        end
        #1 resetn = 1'b0;
        @(negedge clock);
        chk("abort_plot", {31'd0, plot}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_finished", {31'd0, finished}, 32'd0);
        chk("abort_vga", {VGA_X, 1'b0, VGA_Y, VGA_COLOR}, 32'd0);
        chk("abort_rom_addr", {17'd0, rom_addr}, 32'd0);
        sb.delete();
        plots_at_reset = plot_cnt;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (20) @(negedge clock);
        chk("abort_no_plot", plot_cnt, plots_at_reset);
        chk("abort_idle_busy", {31'd0, busy}, 32'd0);
        chk("abort_idle_finished", {31'd0, finished}, 32'd0);
        $display("reset abort checked, plots before reset=%0d", plots_at_reset);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_screen_painter.md
Name: m_screen_painter

Overview:
- Parametrised rectangle renderer: the next generation of the fixed greeting-screen drawer.
- Rasterises a rectangle in row-major order and drives the VGA pixel-write interface (VGA_X/VGA_Y/VGA_COLOR plus plot strobe).
- Three modes: solid fill, ROM image, or ROM image with colour-key transparency.
- Raises a level `finished` that fsm_game_state uses to advance states. One instance per screen/sprite layer.

Parameters:
- X_W, 8, pixel X coordinate width
- Y_W, 7, pixel Y coordinate width
- COLOR_W, 12, pixel colour width (RGB444)
- ADDR_W, 15, image ROM address width
- SCR_W, 160, visible screen width; pixels with x >= SCR_W are clipped
- SCR_H, 120, visible screen height; pixels with y >= SCR_H are clipped
- KEY_COLOR, 12'h0F0, transparent colour in mode KEYED

Ports:
- clock  in  1  system clock
- resetn  in  1  reset
- enable  in  1  global advance; when low the block freezes
- start  in  1  request a draw; sampled only in IDLE/DONE
- mode  in  2  0=FILL, 1=IMAGE, 2=KEYED, 3=reserved (behaves as FILL)
- rect_x  in  X_W  top-left X
- rect_y  in  Y_W  top-left Y
- rect_w  in  X_W  width in pixels
- rect_h  in  Y_W  height in pixels
- fill_color  in  COLOR_W  colour for FILL
- rom_addr  out  ADDR_W  image-local linear address (row*rect_w + col)
- rom_data  in  COLOR_W  ROM output, valid one cycle after rom_addr
- VGA_X  out  X_W  pixel X
- VGA_Y  out  Y_W  pixel Y
- VGA_COLOR  out  COLOR_W  pixel colour
- plot  out  1  pixel write strobe
- busy  out  1  high in LOAD/RUN/FLUSH
- finished  out  1  high in DONE

Behaviour:
Reset and interface
- Reset resetn, asynchronous, active-low; clock clock.
- On reset, all outputs are 0 and the FSM enters IDLE. Reset asserted mid-draw aborts immediately with no further plot.

States
- IDLE: start=1 with enable=1 latches mode, rect_x, rect_y, rect_w, rect_h, fill_color, then goes to LOAD. If the latched rect_w or rect_h is 0, go directly to DONE; no plot occurs.
- LOAD: clears col, row and the address accumulator, then goes to RUN.
- RUN: each enabled cycle issues coordinate (col,row) and rom_addr into pipeline stage 1.
  - col increments; at col == rect_w-1, col wraps to 0, row increments and the address keeps incrementing by 1 (no multiplier).
  - After issuing col == rect_w-1 and row == rect_h-1, go to FLUSH.
- FLUSH: one cycle; stage 2 emits the last pixel, then go to DONE.
- DONE: finished=1, held until the next accepted start, which behaves as in IDLE (finished drops on the edge that accepts start).

Pipeline
- Stage 2 registers VGA_X = rect_x + col and VGA_Y = rect_y + row.
- VGA_COLOR = fill_color for FILL/reserved, rom_data otherwise.
- plot = stage-1 valid AND (rect_x+col) < SCR_W AND (rect_y+row) < SCR_H AND NOT (mode==KEYED AND rom_data==KEY_COLOR).
- Coordinate sums use X_W+1 / Y_W+1 bits so overflow counts as clipped. Clipped and keyed pixels still consume a cycle.
- When plot=0, VGA_X/VGA_Y/VGA_COLOR still update; do not care.

Timing (enable continuously high, N = rect_w*rect_h)
- start sampled at edge E0.
- First plot-eligible pixel after edge E0+3.
- Last after edge E0+2+N.
- finished=1 after edge E0+3+N.

Boundary conditions
- enable=0: counters, FSM and pipeline hold. plot is forced 0 during that cycle, and the held pixel is re-presented when enable returns; no duplicate or lost pixel.
- start while busy: ignored; latched parameters are unaffected by input changes mid-draw.

Decomposition:
- game_pkg holds:
  - mode constants MODE_FILL/IMAGE/KEYED
  - SCR_W/SCR_H defaults
  - COLOR_W
  - state encoding IDLE/LOAD/RUN/FLUSH/DONE
- Sub-module m_raster_counter (parametrised X_W/Y_W/ADDR_W): col/row/address counters with wrap, a last flag and enable; instantiated once.

Test Plan:
- FILL (10,20) 4x2, colour 12'hF00 -> exactly 8 plots, in order (10,20),(11,20),(12,20),(13,20),(10,21)..(13,21), all 12'hF00; finished rises 11 cycles after start.
- IMAGE 3x2 at (0,0), ROM returns data = addr -> plots carry colours 0..5 with rom_addr 0..5, each colour aligned one cycle after its address.
- Clipping: FILL (158,119) 4x2 -> only (158,119) and (159,119) plotted; finished after 11 cycles.
- KEYED 2x2, ROM = {0F0,123,0F0,456} -> plots only at (x+1,y)=12'h123 and (x+1,y+1)=12'h456.
- Stall and busy-start: enable low 5 cycles mid-FILL 4x1 and start pulsed while busy -> 4 plots total, no duplicates, finished delayed exactly 5 cycles.
- Zero size and reset: rect_w=0 -> finished after 1 cycle with no plot; resetn low mid-draw -> all outputs 0, IDLE, plot never asserted again.
